nor_bus_ctrl: RTL

Wishbone-classic slave that converts single-word read/write requests into timed asynchronous NOR flash bus cycles on the NR1B-SQT56 parallel interface. It drives address, CE#, OE#, WE#, and DQ tri-state control. It sits between the internal Wishbone NOR strobe path (from the QSPI command layer) and the SB_IO pad ring in the FPGA top.
- All bus timing is in sysclk cycles, set by parameters.
- Writes are gated on a synchronized RY/BY# with timeout.

---
 rtl/nor_pkg.sv | 29 ++
 rtl/nor_bus_ctrl_if.sv | 31 +++
 rtl/nor_ry_sync.sv | 26 ++
 rtl/nor_bus_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nor_pkg.sv
// Shared definitions for the NOR flash bus controller: FSM state encoding,
// default NR1B-SQT56 timing at sysclk and default bus widths.
package nor_pkg;

  localparam int unsigned NOR_ADDR_W     = 26;
  localparam int unsigned NOR_DATA_W     = 16;

  // Default bus timing, all in sysclk cycles
  localparam int unsigned NOR_T_SETUP    = 2;
  localparam int unsigned NOR_T_PULSE_RD = 6;
  localparam int unsigned NOR_T_PULSE_WR = 4;
  localparam int unsigned NOR_T_HOLD     = 2;
  localparam int unsigned NOR_RY_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAITRY = 3'd1,
    ST_SETUP  = 3'd2,
    ST_PULSE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } nor_state_t;

  // Larger of two values, used to size the shared phase counter
  function automatic int unsigned nor_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nor_bus_ctrl_if.sv
// Wishbone-classic single-word request bus between the NOR strobe path and
// the NOR bus controller.
//   master: drives cyc/stb/we/adr/dat_i, receives dat_o/ack/err
//   slave : the controller side
interface nor_bus_ctrl_if
  import nor_pkg::*;
#(
  parameter int unsigned ADDR_W = NOR_ADDR_W,
  parameter int unsigned DATA_W = NOR_DATA_W
);

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_adr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;
  logic              wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/nor_ry_sync.sv
// Two-flop synchronizer for an asynchronous pad input. Resets to 1 so an
// idle/ready level is presented until the pad has been sampled.
//   clk  : destination clock
//   rst  : synchronous active-high reset
//   din  : asynchronous input
//   dout : synchronized output (second flop)
module nor_ry_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/nor_bus_ctrl.sv
// Wishbone-classic slave that turns single-word read/write requests into
// timed asynchronous NOR flash bus cycles (CE#/OE#/WE#, address, DQ).
// Writes wait for a synchronized RY/BY# with a timeout.
//   clk_i, reset_i : sysclk, synchronous active-high reset
//   wb             : Wishbone request bus (slave side)
//   busy_o         : high whenever the FSM is not idle
//   ry_o           : synchronized RY/BY# (1 = ready)
//   nor_*          : NOR pad-side address, DQ in/out/oe, RY/BY#, strobes
module nor_bus_ctrl
  import nor_pkg::*;
#(
  parameter int unsigned ADDR_W     = NOR_ADDR_W,
  parameter int unsigned DATA_W     = NOR_DATA_W,
  parameter int unsigned T_SETUP    = NOR_T_SETUP,
  parameter int unsigned T_PULSE_RD = NOR_T_PULSE_RD,
  parameter int unsigned T_PULSE_WR = NOR_T_PULSE_WR,
  parameter int unsigned T_HOLD     = NOR_T_HOLD,
  parameter int unsigned RY_TIMEOUT = NOR_RY_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  nor_bus_ctrl_if.slave     wb,
  output logic              busy_o,
  output logic              ry_o,
  output logic [ADDR_W-1:0] nor_addr_o,
  input  logic [DATA_W-1:0] nor_data_i,
  output logic [DATA_W-1:0] nor_data_o,
  output logic              nor_data_oe,
  input  logic              nor_ry_i,
  output logic              nor_ce_o,
  output logic              nor_oe_o,
  output logic              nor_we_o
);

  localparam int unsigned T_MAX =
    nor_max(nor_max(nor_max(T_SETUP, T_PULSE_RD), nor_max(T_PULSE_WR, T_HOLD)), RY_TIMEOUT);
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

  // Terminal count of each phase; a phase ends on the cycle cnt hits these
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PR_LAST    = CNT_W'(T_PULSE_RD - 1);
  localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(T_PULSE_WR - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] RY_LAST    = CNT_W'(RY_TIMEOUT - 1);

  nor_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             dir_wr;

  nor_ry_sync u_ry_sync (
    .clk  (clk_i),
    .rst  (reset_i),
    .din  (nor_ry_i),
    .dout (ry_o)
  );

  // Bus FSM. Pad strobes are registered, so each transition sets the
  // strobe levels that belong to the state being entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dir_wr      <= 1'b0;
      busy_o      <= 1'b0;
      nor_addr_o  <= '0;
      nor_data_o  <= '0;
      nor_data_oe <= 1'b0;
      nor_ce_o    <= 1'b1;
      nor_oe_o    <= 1'b1;
      nor_we_o    <= 1'b1;
      wb.wb_dat_o <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
    end else begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_ack_o && !wb.wb_err_o) begin
            nor_addr_o <= wb.wb_adr_i;
            nor_data_o <= wb.wb_dat_i;
            dir_wr     <= wb.wb_we_i;
            cnt        <= '0;
            busy_o     <= 1'b1;
            if (!wb.wb_we_i || ry_o) begin
              state       <= ST_SETUP;
              nor_ce_o    <= 1'b0;
              nor_data_oe <= wb.wb_we_i;
            end else begin
              state <= ST_WAITRY;
            end
          end
        end

        // Abort has priority; ready is checked before the timeout
        ST_WAITRY: begin
          if (!wb.wb_cyc_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (ry_o) begin
            state       <= ST_SETUP;
            cnt         <= '0;
            nor_ce_o    <= 1'b0;
            nor_data_oe <= 1'b1;
          end else if (cnt == RY_LAST) begin
            state       <= ST_DONE;
            cnt         <= '0;
            wb.wb_err_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state    <= ST_PULSE;
            cnt      <= '0;
            nor_oe_o <= dir_wr;
            nor_we_o <= !dir_wr;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Read data is captured while OE# is still low on the last cycle
        ST_PULSE: begin
          if (cnt == (dir_wr ? PW_LAST : PR_LAST)) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            nor_oe_o <= 1'b1;
            nor_we_o <= 1'b1;
            if (!dir_wr) begin
              wb.wb_dat_o <= nor_data_i;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // An aborted cycle still completes; only the ack is dropped
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state       <= ST_DONE;
            cnt         <= '0;
            nor_ce_o    <= 1'b1;
            nor_data_oe <= 1'b0;
            wb.wb_ack_o <= wb.wb_cyc_i;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Turnaround cycle; ack/err is visible here
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          busy_o      <= 1'b0;
          nor_ce_o    <= 1'b1;
          nor_oe_o    <= 1'b1;
          nor_we_o    <= 1'b1;
          nor_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
